// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: enable/signal inputs and period/valid/locked/timeout outputs of clk_period_meter
interface clk_period_meter_if #(parameter int WIDTH = 16);
  logic en;
  logic sig_in;
  logic [WIDTH-1:0] period;
  logic valid;
  logic locked;
  logic timeout;
  modport master(output en, sig_in, input period, valid, locked, timeout);
  modport slave(input en, sig_in, output period, valid, locked, timeout);
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter: counts i_clk_in cycles between rising edges of io_bus.sig_in; ports i_clk_in, i_rst, io_bus (en, sig_in -> period, valid, locked, timeout)
module clk_period_meter #(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic i_clk_in,
  input logic i_rst,
  clk_period_meter_if.slave io_bus
);
  localparam int SW = $clog2(SYNC_STAGES + 2);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t r_state, w_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_prev;
  logic [SW-1:0] r_settle;
  logic [WIDTH-1:0] r_cnt, w_cnt, r_period, w_period;
  logic r_valid, w_valid, r_locked, w_locked, r_timeout, w_timeout;
  logic w_settled, w_rise, w_sat;
  assign w_settled = r_settle == SW'(SYNC_STAGES + 1);
  assign w_rise = w_settled & r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_sat = &r_cnt;
  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_settle <= '0;
      r_state <= IDLE;
      r_cnt <= '0;
      r_period <= '0;
      r_valid <= 1'b0;
      r_locked <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], io_bus.sig_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_settle <= w_settled ? r_settle : r_settle + SW'(1);
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_period <= w_period;
      r_valid <= w_valid;
      r_locked <= w_locked;
      r_timeout <= w_timeout;
    end
  end
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_period = r_period;
    w_valid = 1'b0;
    w_locked = r_locked;
    w_timeout = r_timeout;
    if (!io_bus.en) begin
      w_state = IDLE;
      w_cnt = '0;
      w_locked = 1'b0;
      w_timeout = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt = '0;
          w_state = w_settled ? ARM : IDLE;
        end
        ARM: begin
          w_cnt = '0;
          w_state = w_rise ? MEASURE : ARM;
        end
        MEASURE: begin
          if (w_sat) begin
            w_timeout = 1'b1;
            w_locked = 1'b0;
            w_cnt = '0;
            w_state = w_rise ? MEASURE : ARM;
          end else if (w_rise) begin
            w_period = r_cnt + WIDTH'(1);
            w_valid = 1'b1;
            w_locked = 1'b1;
            w_timeout = 1'b0;
            w_cnt = '0;
          end else begin
            w_cnt = r_cnt + WIDTH'(1);
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end
  assign io_bus.period = r_period;
  assign io_bus.valid = r_valid;
  assign io_bus.locked = r_locked;
  assign io_bus.timeout = r_timeout;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: scoreboard bench for clk_period_meter (WIDTH=8, SYNC_STAGES=2)
module tb_clk_period_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int last_v = 0;
  typedef struct {
    int per;
    int cyc;
  } exp_t;
  exp_t q[$];
  clk_period_meter_if #(.WIDTH(8)) bus();
  clk_period_meter #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_clk_in(clk),
    .i_rst(rst),
    .io_bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_until(input int t);
    while (cyc < t) wait_cyc(1);
  endtask
  // A level set here is first sampled on the next edge; VALID follows two edges later.
  task automatic pulse(input int hi, input int lo, input bit exp, input int per);
    bus.sig_in = 1'b1;
    if (exp) begin
      last_v = cyc + 3;
      q.push_back('{per: per, cyc: cyc + 3});
    end
    wait_cyc(hi);
    bus.sig_in = 1'b0;
    wait_cyc(lo);
  endtask
  always @(negedge clk) begin
    if (bus.valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("valid_period", int'(bus.period), e.per);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end
  initial begin
    int v;
    bus.en = 1'b0;
    bus.sig_in = 1'b0;
    wait_cyc(3);
    bus.sig_in = 1'b1;
    bus.en = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    chk("rst_period", int'(bus.period), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    wait_cyc(14);
    bus.sig_in = 1'b0;
    wait_cyc(15);
    pulse(20, 20, 1'b0, 0);
    chk("arm_period", int'(bus.period), 0);
    chk("arm_locked", int'(bus.locked), 0);
    for (int i = 0; i < 5; i++) pulse(20, 20, 1'b1, 40);
    chk("steady_locked", int'(bus.locked), 1);
    chk("steady_timeout", int'(bus.timeout), 0);
    v = last_v;
    wait_until(v + 255);
    chk("stall_early_timeout", int'(bus.timeout), 0);
    wait_cyc(1);
    chk("stall_timeout", int'(bus.timeout), 1);
    chk("stall_locked", int'(bus.locked), 0);
    chk("stall_period", int'(bus.period), 40);
    wait_cyc(20);
    pulse(25, 25, 1'b0, 0);
    pulse(25, 25, 1'b1, 50);
    chk("resume_timeout", int'(bus.timeout), 0);
    chk("resume_locked", int'(bus.locked), 1);
    pulse(25, 25, 1'b1, 50);
    v = last_v;
    wait_until(v + 253);
    bus.sig_in = 1'b1;
    wait_until(v + 256);
    chk("sat_timeout", int'(bus.timeout), 1);
    chk("sat_locked", int'(bus.locked), 0);
    chk("sat_period", int'(bus.period), 50);
    wait_cyc(7);
    bus.sig_in = 1'b0;
    wait_cyc(10);
    pulse(10, 10, 1'b1, 20);
    chk("sat_next_period", int'(bus.period), 20);
    chk("sat_next_timeout", int'(bus.timeout), 0);
    pulse(20, 20, 1'b1, 20);
    bus.sig_in = 1'b1;
    q.push_back('{per: 40, cyc: cyc + 3});
    wait_cyc(20);
    bus.sig_in = 1'b0;
    bus.en = 1'b0;
    wait_cyc(1);
    chk("en_drop_locked", int'(bus.locked), 0);
    chk("en_drop_timeout", int'(bus.timeout), 0);
    chk("en_drop_period", int'(bus.period), 40);
    wait_cyc(9);
    bus.en = 1'b1;
    wait_cyc(10);
    pulse(20, 20, 1'b0, 0);
    chk("reen_armed_locked", int'(bus.locked), 0);
    pulse(20, 20, 1'b1, 40);
    chk("reen_locked", int'(bus.locked), 1);
    bus.sig_in = 1'b1;
    q.push_back('{per: 40, cyc: cyc + 3});
    wait_cyc(10);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("mid_rst_period", int'(bus.period), 0);
    chk("mid_rst_locked", int'(bus.locked), 0);
    chk("mid_rst_valid", int'(bus.valid), 0);
    chk("mid_rst_timeout", int'(bus.timeout), 0);
    wait_cyc(10);
    bus.sig_in = 1'b0;
    wait_cyc(10);
    pulse(20, 20, 1'b0, 0);
    chk("rst_rearm_period", int'(bus.period), 0);
    pulse(20, 20, 1'b1, 40);
    chk("rst_final_period", int'(bus.period), 40);
    chk("rst_final_locked", int'(bus.locked), 1);
    wait_cyc(5);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
